snes_poll_scheduler: RTL
========================

Name: snes_poll_scheduler

Overview:
- Sequences the shared SNES/NES controller bus for two player ports. Latch and clock lines are common to both ports; each port has its own data line.
- Polls both pads at a fixed interval and debounces each button over consecutive frames.
- Turns debounced press edges into a held valid/ack event interface for the pinball game logic (flippers, plunger, start).
- Replaces per-port free-running readers with one scheduler that owns the bus.

Parameters:
- HALF_PERIOD, 300: clk_50 cycles per controller_clk half period (6 us at 50 MHz). Minimum value is 1.
- POLL_INTERVAL, 30000: idle clk_50 cycles between end of one frame and next latch rise.
- DEBOUNCE_FRAMES, 3: consecutive identical raw frames needed before a button's stable value changes. Range is 1..15.

Ports:
- clk_50  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- poll_en  in  1  allows new frames to start
- p1_dout  in  1  port 1 serial data, low = pressed
- p2_dout  in  1  port 2 serial data, low = pressed
- controller_latch  out  1  shared latch
- controller_clk  out  1  shared serial clock, idles high
- frame_done  out  1  one-cycle pulse after the 16th bit of each frame
- p1_buttons  out  12  debounced state, active-high
- p2_buttons  out  12  debounced state, active-high
- event_valid  out  1  pending press events exist
- p1_press  out  12  pending press mask, port 1
- p2_press  out  12  pending press mask, port 2
- event_ack  in  1  consumer accepts current masks

Behaviour:
- Reset is asynchronous, active-low, one clock domain.
  - On reset: latch=0, clk=1, frame_done=0, all button/press masks=0, event_valid=0, debounce counters=0, state=IDLE, timer=0.
  - Reset mid-frame aborts the frame immediately; no partial frame is ever committed.
- Button bit order (bit index = serial bit index): 0 B, 1 Y, 2 SELECT, 3 START, 4 N, 5 S, 6 W, 7 E, 8 A, 9 X, 10 L, 11 R. Serial bits 12-15 are clocked out but discarded.
- Raw bit value = ~dout, sampled on the clk_50 edge where controller_clk is driven low.
- FSM states and transitions:
  - IDLE: waits until timer reaches 0 and poll_en=1, then goes to LATCH. The timer is loaded with POLL_INTERVAL on entering IDLE from DONE. After reset it starts at 0, so the first frame begins on the first cycle with poll_en=1.
  - LATCH: latch=1 for 2*HALF_PERIOD cycles, then SETTLE.
  - SETTLE: latch=0, clk=1 for HALF_PERIOD cycles, then CLK_LO with bit index 0.
  - CLK_LO: on entry clk=0 and both dout lines are sampled into shift registers at the current bit index. Lasts HALF_PERIOD cycles, then CLK_HI.
  - CLK_HI: clk=1 for HALF_PERIOD cycles. If bit index is 15, go to DONE; otherwise increment the index and go to CLK_LO.
  - DONE: lasts one cycle, frame_done=1, raw frame committed to the debouncer, then IDLE.
- Frame length: latch rise to frame_done is 35*HALF_PERIOD cycles.
- poll_en=0 mid-frame does not abort; the frame completes and the scheduler stays in IDLE.
- Debounce (per port, per bit): runs once per DONE.
  - raw != stable: counter increments. When it reaches DEBOUNCE_FRAMES, stable takes raw and the counter clears.
  - raw == stable: counter clears.
  - With DEBOUNCE_FRAMES=1, stable follows raw every frame.
- Press events: a stable 0->1 transition ORs that bit into the pending press mask. Release transitions generate no event.
- event_valid = (p1_press | p2_press) != 0, registered together with the masks.
- Handshake: when event_ack=1 and event_valid=1, pending masks clear on the next edge.
  - If a DONE with new presses coincides with the ack, the new presses survive: mask <= new_presses.
  - Presses arriving while pending are OR-accumulated and never dropped.
  - event_ack while event_valid=0 is ignored.

Test Plan:
- Params HALF=4, INTERVAL=20, DEBOUNCE=2; reset, poll_en=1, both dout=1 -> latch high 8 cycles, 16 clk low pulses of 4 cycles, frame_done exactly 140 cycles after latch rise, next latch rise 20 cycles after the idle period begins; all masks stay 0.
- p1 model drives bit 8 (A) low every frame -> p1_buttons=0x100 after 2nd frame_done, not the 1st; p1_press=0x100 and event_valid=1 in the same cycle; p2 masks stay 0.
- Glitch: A pressed for one frame only, DEBOUNCE=2 -> p1_buttons stays 0 and no event.
- Accumulate: START pressed on p2, no ack; 3 frames later p2 L pressed -> p2_press=0x408. Ack -> masks clear and event_valid=0 next cycle.
- Simultaneous: ack asserted in the DONE cycle that debounces p1 B -> p1_press=0x001 afterward and event_valid stays 1.
- Reset pulled low at bit 7 of a frame -> latch=0 and clk=1 immediately. After release with poll_en=1, a full new frame starts and button state remains 0.

Source files
------------

// File: rtl/snes_poll_scheduler.sv
// SNES/NES two-port poll scheduler: drives the shared latch/clock bus, debounces
// each button over whole frames and holds new presses as a valid/ack event.

module snes_debounce_cell #(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic commit,
    input  logic raw,
    output logic stable,
    output logic rise
);
    logic [3:0] cnt;
    logic       hit;

    // hit: this commit is the DEBOUNCE_FRAMES-th consecutive disagreeing frame
    assign hit  = commit && (raw != stable) && (cnt == 4'(DEBOUNCE_FRAMES - 1));
    assign rise = hit && raw;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (commit) begin
            if (raw == stable) begin
                cnt <= '0;
            end else if (hit) begin
                cnt    <= '0;
                stable <= raw;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

module snes_poll_scheduler #(
    parameter int HALF_PERIOD     = 300,
    parameter int POLL_INTERVAL   = 30000,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        poll_en,
    input  logic        p1_dout,
    input  logic        p2_dout,
    output logic        controller_latch,
    output logic        controller_clk,
    output logic        frame_done,
    output logic [11:0] p1_buttons,
    output logic [11:0] p2_buttons,
    output logic        event_valid,
    output logic [11:0] p1_press,
    output logic [11:0] p2_press,
    input  logic        event_ack
);
    localparam int NUM_PORTS = 2;
    localparam int BTN_W     = 12;
    localparam int T_MAX     = (POLL_INTERVAL > 2 * HALF_PERIOD) ? POLL_INTERVAL : 2 * HALF_PERIOD;
    localparam int TW        = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] T_LATCH = TW'(2 * HALF_PERIOD - 1);
    localparam logic [TW-1:0] T_HALF  = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] T_POLL  = TW'(POLL_INTERVAL);
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SETTLE, S_CLK_LO, S_CLK_HI, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [3:0]    bit_idx, bit_idx_nxt;
    logic          sample;
    logic          commit;

    logic [NUM_PORTS-1:0][BTN_W-1:0] raw_q;
    logic [NUM_PORTS-1:0][BTN_W-1:0] stable;
    logic [NUM_PORTS-1:0][BTN_W-1:0] rise;
    logic [NUM_PORTS-1:0][BTN_W-1:0] press_q, press_nxt;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    // Timed states load duration-1 and leave at zero. IDLE is loaded with the
    // full interval and leaves as its countdown reaches zero, giving exactly
    // POLL_INTERVAL idle cycles; from reset the timer is already zero.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_idx_nxt = bit_idx;
        sample      = 1'b0;
        case (state)
            S_IDLE: begin
                if (timer != '0) timer_nxt = timer - T_ONE;
                if (poll_en && timer <= T_ONE) begin
                    state_nxt = S_LATCH;
                    timer_nxt = T_LATCH;
                end
            end
            S_LATCH: begin
                if (timer == '0) begin
                    state_nxt = S_SETTLE;
                    timer_nxt = T_HALF;
                end else begin
                    timer_nxt = timer - T_ONE;
                end
            end
            S_SETTLE: begin
                if (timer == '0) begin
                    state_nxt   = S_CLK_LO;
                    timer_nxt   = T_HALF;
                    bit_idx_nxt = '0;
                    sample      = 1'b1;
                end else begin
                    timer_nxt = timer - T_ONE;
                end
            end
            S_CLK_LO: begin
                if (timer == '0) begin
                    state_nxt = S_CLK_HI;
                    timer_nxt = T_HALF;
                end else begin
                    timer_nxt = timer - T_ONE;
                end
            end
            S_CLK_HI: begin
                if (timer == '0) begin
                    if (bit_idx == 4'd15) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt   = S_CLK_LO;
                        timer_nxt   = T_HALF;
                        bit_idx_nxt = bit_idx + 4'd1;
                        sample      = 1'b1;
                    end
                end else begin
                    timer_nxt = timer - T_ONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                timer_nxt = T_POLL;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus pins are registered from the next state, so data is sampled on the
    // same edge that drives controller_clk low.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            controller_latch <= 1'b0;
            controller_clk   <= 1'b1;
            frame_done       <= 1'b0;
        end else begin
            controller_latch <= (state_nxt == S_LATCH);
            controller_clk   <= (state_nxt != S_CLK_LO);
            frame_done       <= (state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= '0;
        end else if (sample) begin
            for (int b = 0; b < BTN_W; b++) begin
                if (bit_idx_nxt == 4'(b)) begin
                    raw_q[0][b] <= ~p1_dout;
                    raw_q[1][b] <= ~p2_dout;
                end
            end
        end
    end

    assign commit = (state == S_DONE);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        for (genvar b = 0; b < BTN_W; b++) begin : g_btn
            snes_debounce_cell #(
                .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
            ) u_cell (
                .clk_50 (clk_50),
                .rst_n  (rst_n),
                .commit (commit),
                .raw    (raw_q[p][b]),
                .stable (stable[p][b]),
                .rise   (rise[p][b])
            );
        end
    end

    // An accepted ack drops what was pending but keeps presses landing this edge.
    assign press_nxt = (event_ack && event_valid) ? rise : (press_q | rise);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            press_q     <= '0;
            event_valid <= 1'b0;
        end else begin
            press_q     <= press_nxt;
            event_valid <= |press_nxt;
        end
    end

    assign p1_buttons = stable[0];
    assign p2_buttons = stable[1];
    assign p1_press   = press_q[0];
    assign p2_press   = press_q[1];
endmodule
